// File: rtl/param_register_file.sv
// Parametrised register bank: one byte-masked write port and two registered
// read ports with write-first bypass, optional hard-wired zero entry and clear.
module param_register_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic [WIDTH/8-1:0]   byte_en_i,
  input  logic                 rd_en_a_i,
  input  logic [ADDR_W-1:0]    rd_addr_a_i,
  output logic [WIDTH-1:0]     rd_data_a_o,
  input  logic                 rd_en_b_i,
  input  logic [ADDR_W-1:0]    rd_addr_b_i,
  output logic [WIDTH-1:0]     rd_data_b_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic             wr_blocked;

  assign wr_blocked = (ZERO_REG != 0) && (wr_addr_i == '0);

  // Reads sample mem_d, so a same-cycle write is already merged in (write-first).
  always_comb begin
    mem_d  = mem_q;
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      rd_a_d = '0;
      rd_b_d = '0;
    end else begin
      if (we_i && !wr_blocked) begin
        for (int b = 0; b < NB; b++) begin
          if (byte_en_i[b]) mem_d[wr_addr_i][8*b +: 8] = wr_data_i[8*b +: 8];
        end
      end
      if (rd_en_a_i) begin
        rd_a_d = ((ZERO_REG != 0) && (rd_addr_a_i == '0)) ? '0 : mem_d[rd_addr_a_i];
      end
      if (rd_en_b_i) begin
        rd_b_d = ((ZERO_REG != 0) && (rd_addr_b_i == '0)) ? '0 : mem_d[rd_addr_b_i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_data_a_o = rd_a_q;
  assign rd_data_b_o = rd_b_q;

endmodule
